ex_forward_ctrl: RTL and testbench
==================================

# ex_forward_ctrl

- Forwarding and load-use hazard controller for the 16-bit five-stage pipeline.
- Tracks destination-register state of the instructions in EX and MEM, and compares it against the source registers of the instruction in ID.
- Drives, registered at the ID->EX edge, the select pairs of the two 4:1 16-bit EX-stage operand muxes.
- Raises a combinational stall on load-use hazards and inserts a bubble into EX.

## Interface
Parameters:
- REG_W, 3, register-specifier width (8 architectural registers; register 0 reads as zero)

Ports (clk/rst: one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  source A specifier
- id_rt  in  REG_W  source B specifier
- id_rt_used  in  1  instruction reads rt as a register
- id_use_imm  in  1  operand B is the immediate
- id_rd  in  REG_W  destination specifier
- id_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  kill instruction in ID (taken branch/jump)
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_a_s0, ex_a_s1  out  1 each  operand-A mux selects (registered)
- ex_b_s0, ex_b_s1  out  1 each  operand-B mux selects (registered)
- stall_count  out  16  saturating count of stall cycles

## Operation
Select encoding {s1,s0}:
- 00: register-file value
- 01: EX/MEM ALU result
- 10: MEM/WB write-back value
- 11: immediate (operand B only; operand A never receives 11)

Internal state:
- Two slot registers, ex_slot and mem_slot, each holding {valid, rd, we, load}.
- A slot "matches" register r when valid & we & rd==r & r!=0.

Stall:
- stall = id_valid & !flush & ex_slot.load & ex_slot matches (id_rs, or id_rt when id_rt_used & !id_use_imm).
- Stall is a function of registered state and ID inputs only.

Select computation, per operand, evaluated in ID:
- If ex_slot matches → 01.
- Else if mem_slot matches → 10.
- Else → 00.
- For operand B: if id_use_imm → 11 regardless of matches; if !id_rt_used & !id_use_imm → 00.

Per clock (rst=0):
- mem_slot <= ex_slot.
- If id_valid & !stall & !flush: ex_slot <= {1, id_rd, id_we, id_is_load} and the selects load their computed values.
- Otherwise: ex_slot <= bubble {0,0,0,0} and all selects <= 00.
- stall_count increments when stall=1, saturating at 16'hFFFF.

Decided facts:
- The register file writes before it reads; a producer leaving WB needs no forwarding.
- flush has priority over stall; flush=1 forces stall=0.

## Timing
- Reset (rst=1 at an edge):
  - both slots invalid, all four selects 0, stall_count 0
  - stall reads 0 from the following cycle
- rst asserted mid-stall: the next edge clears state; a pending stall is dropped; selects return to 00.
- Select latency: computed in cycle N (instruction in ID), valid throughout cycle N+1 (instruction in EX), aligned with the operand muxes.
- Load-use:
  - stall is high for exactly one cycle; EX receives a bubble.
  - Next cycle the load sits in mem_slot, stall falls, and the dependent operand select = 10.
- Two back-to-back loads feeding one consumer: one stall cycle, then the nearer load wins and the select is 10.
- Bubble or invalid ID instructions never create matches downstream.

## Test plan
- Reset: assert rst 2 cycles with id_valid=1 → all selects 0, stall=0, stall_count=0.
- Distance-1 ALU dependency: r3=add, then sub reading rs=r3 → A select 01 in the sub's EX cycle. Distance 2 (one unrelated instruction between) → 10.
- Priority: r2 written at distance 1 and 2, consumer reads rs=rt=r2 (id_rt_used=1) → A=01, B=01.
- Load-use: lw r4, then add rs=r4 → stall=1 one cycle, bubble in EX, then A=10, stall_count=1.
- Zero/immediate: producer writes r0, consumer reads r0 → 00. Producer writes r5, consumer has rt=r5 with id_use_imm=1 → B=11.
- Flush vs stall: load-use condition with flush=1 same cycle → stall=0, EX bubble, selects 00, stall_count unchanged. Drive stall 65536+ cycles → stall_count holds 16'hFFFF.

Source files
------------

// File: rtl/ex_forward_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_forward_ctrl_if
// Description : ID-stage hazard bus between the pipeline and ex_forward_ctrl.
// Revision    : 1.0
// ============================================================================
interface ex_forward_ctrl_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rt_used;
    logic             id_use_imm;
    logic [REG_W-1:0] id_rd;
    logic             id_we;
    logic             id_is_load;
    logic             flush;
    logic             stall;
    logic             ex_a_s0;
    logic             ex_a_s1;
    logic             ex_b_s0;
    logic             ex_b_s1;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_use_imm,
               id_rd, id_we, id_is_load, flush,
        input  stall, ex_a_s0, ex_a_s1, ex_b_s0, ex_b_s1, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_use_imm,
               id_rd, id_we, id_is_load, flush,
        output stall, ex_a_s0, ex_a_s1, ex_b_s0, ex_b_s1, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/ex_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_forward_ctrl
// Description : EX operand-forwarding selects and load-use stall generation.
// Revision    : 1.0
// ============================================================================
module ex_forward_ctrl #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ex_forward_ctrl_if.slave   bus
);

    localparam logic [1:0]       SEL_RF  = 2'b00;
    localparam logic [1:0]       SEL_EXM = 2'b01;
    localparam logic [1:0]       SEL_MWB = 2'b10;
    localparam logic [1:0]       SEL_IMM = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             load;
    } slot_t;

    slot_t      ex_q;
    slot_t      mem_q;
    logic [1:0] a_sel_q;
    logic [1:0] b_sel_q;
    logic [1:0] a_sel_d;
    logic [1:0] b_sel_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic w_b_reads;
    logic w_stall;
    logic w_advance;

    function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] r);
        return s.valid & s.we & (s.rd == r) & (r != '0);
    endfunction

    assign w_b_reads = bus.id_rt_used & ~bus.id_use_imm;

    // Only a load one stage ahead is unresolvable; anything further is forwarded.
    assign w_stall = bus.id_valid & ~bus.flush & ex_q.load &
                     (slot_match(ex_q, bus.id_rs) |
                      (w_b_reads & slot_match(ex_q, bus.id_rt)));

    assign w_advance = bus.id_valid & ~w_stall & ~bus.flush;

    always_comb begin
        a_sel_d = SEL_RF;
        if (slot_match(ex_q, bus.id_rs)) begin
            a_sel_d = SEL_EXM;
        end else if (slot_match(mem_q, bus.id_rs)) begin
            a_sel_d = SEL_MWB;
        end

        b_sel_d = SEL_RF;
        if (bus.id_use_imm) begin
            b_sel_d = SEL_IMM;
        end else if (bus.id_rt_used) begin
            if (slot_match(ex_q, bus.id_rt)) begin
                b_sel_d = SEL_EXM;
            end else if (slot_match(mem_q, bus.id_rt)) begin
                b_sel_d = SEL_MWB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            a_sel_q     <= SEL_RF;
            b_sel_q     <= SEL_RF;
            stall_cnt_q <= '0;
        end else begin
            mem_q <= ex_q;
            if (w_advance) begin
                ex_q    <= '{valid: 1'b1, rd: bus.id_rd, we: bus.id_we, load: bus.id_is_load};
                a_sel_q <= a_sel_d;
                b_sel_q <= b_sel_d;
            end else begin
                ex_q    <= '0;
                a_sel_q <= SEL_RF;
                b_sel_q <= SEL_RF;
            end
            if (w_stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.ex_a_s0     = a_sel_q[0];
    assign bus.ex_a_s1     = a_sel_q[1];
    assign bus.ex_b_s0     = b_sel_q[0];
    assign bus.ex_b_s1     = b_sel_q[1];
    assign bus.stall_count = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_forward_ctrl
// Description : Directed-vector bench for ex_forward_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_ex_forward_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    int   n_sat_stalls;

    ex_forward_ctrl_if #(.REG_W(3), .CNT_W(16)) bus  ();
    ex_forward_ctrl_if #(.REG_W(3), .CNT_W(3))  bus2 ();

    ex_forward_ctrl #(.REG_W(3), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    ex_forward_ctrl #(.REG_W(3), .CNT_W(3)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                          input logic ru, input logic imm, input logic [2:0] rd,
                          input logic we, input logic ld);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rt_used = ru;
        bus.id_use_imm = imm;
        bus.id_rd      = rd;
        bus.id_we      = we;
        bus.id_is_load = ld;
    endtask

    task automatic nop();
        set_id(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [15:0] a_sel();
        return {14'd0, bus.ex_a_s1, bus.ex_a_s0};
    endfunction

    function automatic logic [15:0] b_sel();
        return {14'd0, bus.ex_b_s1, bus.ex_b_s0};
    endfunction

    initial begin
        n_chk = 0;
        n_pass = 0;
        n_sat_stalls = 0;
        bus.flush = 1'b0;
        bus2.flush = 1'b0;
        bus2.id_valid = 1'b0;
        bus2.id_rs = 3'd0;
        bus2.id_rt = 3'd0;
        bus2.id_rt_used = 1'b0;
        bus2.id_use_imm = 1'b0;
        bus2.id_rd = 3'd0;
        bus2.id_we = 1'b0;
        bus2.id_is_load = 1'b0;

        // Reset with a valid load sitting in ID
        rst = 1'b1;
        set_id(1'b1, 3'd3, 3'd3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1);
        tick();
        tick();
        check("rst_a_sel", a_sel(), 16'd0);
        check("rst_b_sel", b_sel(), 16'd0);
        check("rst_count", bus.stall_count, 16'd0);
        check("rst_stall", {15'd0, bus.stall}, 16'd0);
        nop();
        rst = 1'b0;
        tick();

        // Distance-1 ALU dependency
        set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
        #1 check("d1_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        check("d1_a_sel", a_sel(), 16'd1);
        check("d1_b_sel", b_sel(), 16'd0);

        // Distance-2 dependency, rt not used
        set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        tick();
        check("d2_a_sel", a_sel(), 16'd2);
        check("d2_b_sel", b_sel(), 16'd0);

        // Nearer producer wins
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
        tick();
        check("prio_a_sel", a_sel(), 16'd1);
        check("prio_b_sel", b_sel(), 16'd1);

        // Load-use: one stall, bubble, then forward from MEM/WB
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd4, 3'd5, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
        #1 check("lu_stall_hi", {15'd0, bus.stall}, 16'd1);
        tick();
        check("lu_bubble_a", a_sel(), 16'd0);
        check("lu_bubble_b", b_sel(), 16'd0);
        check("lu_stall_lo", {15'd0, bus.stall}, 16'd0);
        check("lu_count", bus.stall_count, 16'd1);
        tick();
        check("lu_a_sel", a_sel(), 16'd2);
        check("lu_b_sel", b_sel(), 16'd0);
        check("lu_count_hold", bus.stall_count, 16'd1);

        // Back-to-back loads into one consumer
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd4, 3'd1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
        #1 check("bb_stall_hi", {15'd0, bus.stall}, 16'd1);
        tick();
        check("bb_stall_lo", {15'd0, bus.stall}, 16'd0);
        tick();
        check("bb_a_sel", a_sel(), 16'd2);
        check("bb_count", bus.stall_count, 16'd2);

        // Writes to r0 never forward
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
        tick();
        check("zero_a_sel", a_sel(), 16'd0);
        check("zero_b_sel", b_sel(), 16'd0);

        // Immediate operand overrides a live match on rt
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd6, 3'd5, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
        tick();
        check("imm_b_sel", b_sel(), 16'd3);
        check("imm_a_sel", a_sel(), 16'd0);

        // Flush beats stall; the flushed instruction leaves a bubble
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd4, 3'd1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1 check("fl_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        bus.flush = 1'b0;
        check("fl_a_sel", a_sel(), 16'd0);
        check("fl_b_sel", b_sel(), 16'd0);
        check("fl_count", bus.stall_count, 16'd2);
        set_id(1'b1, 3'd6, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        #1 check("fl_next_stall", {15'd0, bus.stall}, 16'd0);
        tick();
        check("fl_no_match", a_sel(), 16'd0);

        // Invalid ID instruction never produces a match
        set_id(1'b0, 3'd1, 3'd1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 3'd3, 3'd1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
        tick();
        check("inv_a_sel", a_sel(), 16'd0);

        // Reset during a pending stall
        set_id(1'b1, 3'd1, 3'd1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 3'd4, 3'd1, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0);
        #1 check("mr_stall_hi", {15'd0, bus.stall}, 16'd1);
        rst = 1'b1;
        tick();
        check("mr_stall_lo", {15'd0, bus.stall}, 16'd0);
        check("mr_a_sel", a_sel(), 16'd0);
        check("mr_count", bus.stall_count, 16'd0);
        rst = 1'b0;
        nop();

        // Saturation: self-dependent load stalls every other cycle
        bus2.id_valid   = 1'b1;
        bus2.id_rs      = 3'd4;
        bus2.id_rd      = 3'd4;
        bus2.id_we      = 1'b1;
        bus2.id_is_load = 1'b1;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (bus2.stall === 1'b1) n_sat_stalls++;
            tick();
        end
        check("sat_seen", {15'd0, (n_sat_stalls > 8)}, 16'd1);
        check("sat_count", {13'd0, bus2.stall_count}, 16'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
